lsp_expand2_pipe: RTL and testbench

// - G.729 Lsp_expand_2 stage of the Relspwed LSP reconstruction, bit-exact to the ITU C code.
// - Operates in place on a 10-word LSP buffer buf[0..9] held in an internal scratch memory.
// - For j=5..9: diff=sub(buf[j-1],buf[j]); tmp=shr(add(diff,GAP),1);
//   if tmp>0 then buf[j-1]=sub(buf[j-1],tmp) and buf[j]=add(buf[j],tmp).
// - Test mux gives the bench direct access to the memory for load and readback.

---
 rtl/lsp_expand2_pipe_pkg.sv | 41 ++++
 rtl/lsp_expand2_pipe_if.sv | 21 ++
 rtl/lsp_expand2_pipe_scratch_memory_controller.sv | 20 ++
 rtl/lsp_expand2_pipe.sv | 114 +++++++++++
 tb/tb_lsp_expand2_pipe.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsp_expand2_pipe_pkg.sv
// Shared constants, state encoding and saturating 16-bit primitives for the
// LSP expansion pass (bit-exact to the G.729 basic operators).
package lsp_expand2_pipe_pkg;

    localparam logic [10:0]        RELSPWED_BUF = 11'h0A0;
    localparam logic signed [15:0] GAP1         = 16'sd10;
    localparam logic [3:0]         NC           = 4'd5;
    localparam logic [3:0]         M            = 4'd10;

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, WT, CALC, WR0, WR1, NEXT, DONE
    } state_t;

    function automatic logic [10:0] buf_addr(input logic [3:0] i);
        return {RELSPWED_BUF[10:4], i};
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
        if (x > 17'sd32767)
            return 16'sh7FFF;
        else if (x < -17'sd32768)
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

    function automatic logic signed [15:0] add16(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
        return sat16({a[15], a} + {b[15], b});
    endfunction

    function automatic logic signed [15:0] sub16(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
        return sat16({a[15], a} - {b[15], b});
    endfunction

    function automatic logic signed [15:0] shr1(input logic signed [15:0] a);
        return a >>> 1;
    endfunction

endpackage

// File: rtl/lsp_expand2_pipe_if.sv
// Control and test-port bundle: start/done handshake plus direct scratch-memory access.
interface lsp_expand2_pipe_if;
    logic        start;
    logic        expand2MuxSel;
    logic [10:0] testReadAddr;
    logic [10:0] testWriteAddr;
    logic [31:0] testMemOut;
    logic        testMemWriteEn;
    logic [31:0] memIn;
    logic        done;

    modport master (
        output start, expand2MuxSel, testReadAddr, testWriteAddr, testMemOut, testMemWriteEn,
        input  memIn, done
    );

    modport slave (
        input  start, expand2MuxSel, testReadAddr, testWriteAddr, testMemOut, testMemWriteEn,
        output memIn, done
    );
endinterface

// File: rtl/lsp_expand2_pipe_scratch_memory_controller.sv
// 2048x32 scratch RAM: one write port, one read port, registered read data.
module scratch_memory_controller #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/lsp_expand2_pipe.sv
// In-place Lsp_expand_2 over buf[4..9] in scratch memory; a test mux hands the
// RAM to the external port for loading and readback.
module lsp_expand2_pipe
    import lsp_expand2_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    lsp_expand2_pipe_if.slave  bus
);
    state_t             state;
    logic [3:0]         j;
    logic signed [15:0] a, b, tmp;
    logic [10:0]        fsm_raddr, fsm_waddr;
    logic [31:0]        fsm_wdata;
    logic               fsm_we;
    logic               done_r;

    logic [10:0]        ram_raddr, ram_waddr;
    logic [31:0]        ram_wdata, ram_rdata;
    logic               ram_we;

    logic signed [15:0] tmp_c;
    logic [3:0]         j_m1;

    assign tmp_c = shr1(add16(sub16(a, b), GAP1));
    assign j_m1  = j - 4'd1;

    // Whole-port mux: the side not selected cannot touch the RAM at all.
    assign ram_raddr = bus.expand2MuxSel ? bus.testReadAddr   : fsm_raddr;
    assign ram_waddr = bus.expand2MuxSel ? bus.testWriteAddr  : fsm_waddr;
    assign ram_wdata = bus.expand2MuxSel ? bus.testMemOut     : fsm_wdata;
    assign ram_we    = bus.expand2MuxSel ? bus.testMemWriteEn : fsm_we;

    assign bus.memIn = ram_rdata;
    assign bus.done  = done_r;

    scratch_memory_controller #(.AW(11), .DW(32)) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            j         <= NC;
            a         <= '0;
            b         <= '0;
            tmp       <= '0;
            fsm_raddr <= '0;
            fsm_waddr <= '0;
            fsm_wdata <= '0;
            fsm_we    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            fsm_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        j         <= NC;
                        fsm_raddr <= buf_addr(NC - 4'd1);
                        done_r    <= 1'b0;
                        state     <= RD0;
                    end
                end
                RD0: begin
                    fsm_raddr <= buf_addr(j);
                    state     <= RD1;
                end
                RD1: begin
                    a     <= ram_rdata[15:0];
                    state <= WT;
                end
                WT: begin
                    b     <= ram_rdata[15:0];
                    state <= CALC;
                end
                CALC: begin
                    tmp <= tmp_c;
                    if (tmp_c > 16'sd0) begin
                        fsm_waddr <= buf_addr(j_m1);
                        fsm_wdata <= {16'h0000, sub16(a, tmp_c)};
                        fsm_we    <= 1'b1;
                        state     <= WR0;
                    end else begin
                        state <= NEXT;
                    end
                end
                WR0: begin
                    fsm_waddr <= buf_addr(j);
                    fsm_wdata <= {16'h0000, add16(b, tmp)};
                    fsm_we    <= 1'b1;
                    state     <= WR1;
                end
                WR1: state <= NEXT;
                NEXT: begin
                    if (j == M - 4'd1) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        // Next pair starts at the freshly written buf[j].
                        j         <= j + 4'd1;
                        fsm_raddr <= buf_addr(j);
                        state     <= RD0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsp_expand2_pipe.sv
// Directed-vector bench for lsp_expand2_pipe: load via test port, run a pass, read back.
module tb_lsp_expand2_pipe;
    import lsp_expand2_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsp_expand2_pipe_if bus();

    lsp_expand2_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] vec   [10];
    logic [15:0] exp_v [10];
    logic [31:0] rd;
    int          cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec();
        bus.expand2MuxSel = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.testWriteAddr  = RELSPWED_BUF + 11'(i);
            bus.testMemOut     = {16'h0000, vec[i]};
            bus.testMemWriteEn = 1'b1;
            tick();
        end
        bus.testMemWriteEn = 1'b0;
    endtask

    task automatic read_word(input int i, output logic [31:0] d);
        bus.expand2MuxSel = 1'b1;
        bus.testReadAddr  = RELSPWED_BUF + 11'(i);
        tick();
        d = bus.memIn;
    endtask

    // Pulse start, optionally pulse it again at cycle extra_at, wait for done (bounded).
    task automatic run_pass(input int extra_at, output int c);
        bus.expand2MuxSel = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (bus.done !== 1'b1 && c < 60) begin
            if (c == extra_at) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            c++;
        end
        bus.expand2MuxSel = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 0", bus.done);
        end
    endtask

    task automatic test_equal_pair();
        vec   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1000, 16'd1000, 16'd8000, 16'd9000, 16'd10000, 16'd11000};
        exp_v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd995,  16'd1005, 16'd8000, 16'd9000, 16'd10000, 16'd11000};
        load_vec();
        run_pass(-1, cyc);
        n_checks++;
        if (bus.done !== 1'b1 || cyc > 35) begin
            n_fail++;
            $display("FAIL equal_pair_latency: done=%b after %0d cycles, expected done=1 within 35", bus.done, cyc);
        end
        for (int i = 0; i < 10; i++) begin
            read_word(i, rd);
            n_checks++;
            if (rd !== {16'h0000, exp_v[i]}) begin
                n_fail++;
                $display("FAIL equal_pair word %0d: got %h expected %h", i, rd, {16'h0000, exp_v[i]});
            end
        end
    endtask

    task automatic test_well_spaced();
        for (int k = 0; k < 10; k++) vec[k] = 16'(1000 * k);
        load_vec();
        run_pass(-1, cyc);
        n_checks++;
        if (bus.done !== 1'b1 || cyc > 35) begin
            n_fail++;
            $display("FAIL well_spaced_latency: done=%b after %0d cycles, expected done=1 within 35", bus.done, cyc);
        end
        for (int i = 0; i < 10; i++) begin
            read_word(i, rd);
            n_checks++;
            if (rd !== 32'(1000 * i)) begin
                n_fail++;
                $display("FAIL well_spaced word %0d: got %h expected %h", i, rd, 32'(1000 * i));
            end
        end
    endtask

    // All equal: each j widens the pair using the buf[j] just written; a
    // second start mid-pass must be ignored.
    task automatic test_cascade_busy_start();
        vec   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd5000, 16'd5000, 16'd5000, 16'd5000, 16'd5000, 16'd5000};
        exp_v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd4995, 16'd4998, 16'd4999, 16'd4999, 16'd5000, 16'd5009};
        load_vec();
        run_pass(20, cyc);
        n_checks++;
        if (bus.done !== 1'b1 || cyc > 35) begin
            n_fail++;
            $display("FAIL cascade_latency: done=%b after %0d cycles, expected done=1 within 35", bus.done, cyc);
        end
        for (int i = 0; i < 10; i++) begin
            read_word(i, rd);
            n_checks++;
            if (rd !== {16'h0000, exp_v[i]}) begin
                n_fail++;
                $display("FAIL cascade word %0d: got %h expected %h", i, rd, {16'h0000, exp_v[i]});
            end
        end
    endtask

    task automatic test_saturation();
        vec   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'h7FFF, 16'h8000, 16'd28000, 16'd29000, 16'd30000, 16'd31000};
        exp_v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'h4000, 16'hBFFF, 16'd28000, 16'd29000, 16'd30000, 16'd31000};
        load_vec();
        run_pass(-1, cyc);
        n_checks++;
        if (bus.done !== 1'b1 || cyc > 35) begin
            n_fail++;
            $display("FAIL saturation_latency: done=%b after %0d cycles, expected done=1 within 35", bus.done, cyc);
        end
        for (int i = 0; i < 10; i++) begin
            read_word(i, rd);
            n_checks++;
            if (rd !== {16'h0000, exp_v[i]}) begin
                n_fail++;
                $display("FAIL saturation word %0d: got %h expected %h", i, rd, {16'h0000, exp_v[i]});
            end
        end
    endtask

    // diff=-10 and diff=-9 give tmp=0 (no write); diff=-8 gives tmp=1.
    task automatic test_gap_boundary();
        vec   = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd100, 16'd110, 16'd119, 16'd127, 16'd20000, 16'd21000};
        exp_v = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd100, 16'd110, 16'd118, 16'd128, 16'd20000, 16'd21000};
        load_vec();
        run_pass(-1, cyc);
        n_checks++;
        if (bus.done !== 1'b1 || cyc > 35) begin
            n_fail++;
            $display("FAIL gap_boundary_latency: done=%b after %0d cycles, expected done=1 within 35", bus.done, cyc);
        end
        for (int i = 0; i < 10; i++) begin
            read_word(i, rd);
            n_checks++;
            if (rd !== {16'h0000, exp_v[i]}) begin
                n_fail++;
                $display("FAIL gap_boundary word %0d: got %h expected %h", i, rd, {16'h0000, exp_v[i]});
            end
        end
    endtask

    // Reload while parked in DONE, then re-pulse start straight from DONE.
    task automatic test_back_to_back();
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_held: got %b expected 1", bus.done);
        end
        vec   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1000, 16'd1000, 16'd8000, 16'd9000, 16'd10000, 16'd11000};
        exp_v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd995,  16'd1005, 16'd8000, 16'd9000, 16'd10000, 16'd11000};
        load_vec();
        bus.expand2MuxSel = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_clear: got %b expected 0", bus.done);
        end
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || cyc > 35) begin
            n_fail++;
            $display("FAIL b2b_latency: done=%b after %0d cycles, expected done=1 within 35", bus.done, cyc);
        end
        for (int i = 0; i < 10; i++) begin
            read_word(i, rd);
            n_checks++;
            if (rd !== {16'h0000, exp_v[i]}) begin
                n_fail++;
                $display("FAIL b2b word %0d: got %h expected %h", i, rd, {16'h0000, exp_v[i]});
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        vec   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1000, 16'd1000, 16'd8000, 16'd9000, 16'd10000, 16'd11000};
        exp_v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd995,  16'd1005, 16'd8000, 16'd9000, 16'd10000, 16'd11000};
        load_vec();
        bus.expand2MuxSel = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_done: got %b expected 0", bus.done);
        end
        repeat (40) tick();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: done=%b after 40 idle cycles, expected 0", bus.done);
        end
        // j=5 writes landed before the abort; a fresh pass leaves them stable.
        run_pass(-1, cyc);
        n_checks++;
        if (bus.done !== 1'b1 || cyc > 35) begin
            n_fail++;
            $display("FAIL reset_mid_latency: done=%b after %0d cycles, expected done=1 within 35", bus.done, cyc);
        end
        for (int i = 0; i < 10; i++) begin
            read_word(i, rd);
            n_checks++;
            if (rd !== {16'h0000, exp_v[i]}) begin
                n_fail++;
                $display("FAIL reset_mid word %0d: got %h expected %h", i, rd, {16'h0000, exp_v[i]});
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.expand2MuxSel  = 1'b1;
        bus.testReadAddr   = '0;
        bus.testWriteAddr  = '0;
        bus.testMemOut     = '0;
        bus.testMemWriteEn = 1'b0;
        test_reset();
        test_equal_pair();
        test_well_spaced();
        test_cascade_busy_start();
        test_saturation();
        test_gap_boundary();
        test_back_to_back();
        test_reset_mid_pass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
